sfx_tone_engine: RTL and testbench

- Parametrised multi-channel sound-effect generator for paddle-hit, wall-hit and score events; sits between game-event logic and the audio_codec write interface.
- Each channel is a retriggerable square-wave tone with a programmable half-period, a duration, and an optional exponential decay envelope.
- A most-recent-trigger arbiter selects the single channel driven to both codec outputs.
- Replaces fixed per-event tone counters and a single shared hold-timer.

---
 rtl/sfx_tone_engine_pkg.sv | 32 +++
 rtl/sfx_tone_engine_if.sv | 31 +++
 rtl/sfx_tone_engine_channel.sv | 84 ++++++++
 rtl/sfx_tone_engine.sv | 106 ++++++++++
 tb/tb_sfx_tone_engine.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfx_tone_engine_pkg.sv
// sfx_pkg: shared types and defaults for the sound-effect tone engine.
//   sample_t       signed codec sample
//   channel_cfg_t  per-channel half-period / duration pair
//   DEF_*          default amplitude and decay settings
//   CH_*           event-to-channel assignment used by the game logic
//   ch_w()         width of a channel index (at least 1 bit)
package sfx_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int DEF_CNT_W = 20;
    localparam int DEF_DUR_W = 22;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] half_period;
        logic [DEF_DUR_W-1:0] duration;
    } channel_cfg_t;

    localparam logic [SAMPLE_W-1:0] DEF_AMP = 24'h0FFFFF;
    localparam int DEF_DECAY_CYC   = 500000;
    localparam int DEF_DECAY_SHIFT = 3;

    localparam int CH_P1   = 0;
    localparam int CH_P2   = 1;
    localparam int CH_WALL = 2;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sfx_tone_engine_if.sv
// Codec write interface of the tone engine.
//   write_ready      codec FIFO can accept a sample
//   write            write strobe
//   writedata_left   left sample
//   writedata_right  right sample
// master: tone engine side, slave: codec side.
interface sfx_tone_engine_if #(
    parameter int SAMPLE_W = 24
);
    import sfx_pkg::*;

    logic                       write_ready;
    logic                       write;
    logic signed [SAMPLE_W-1:0] writedata_left;
    logic signed [SAMPLE_W-1:0] writedata_right;

    modport master (
        input  write_ready,
        output write,
        output writedata_left,
        output writedata_right
    );

    modport slave (
        output write_ready,
        input  write,
        input  writedata_left,
        input  writedata_right
    );

endinterface

// File: rtl/sfx_tone_engine_channel.sv
// sfx_tone_channel: one retriggerable square-wave tone with optional
// exponential decay.
//   clk_i, reset_n_i  clock, async active-low reset
//   trig_i            one-cycle start/restart pulse
//   hp_i, dur_i       half-period and length in cycles, sampled at trig_i
//   sample_o          +amp / -amp while sounding, 0 otherwise
//   active_o          tone is sounding (remaining duration non-zero)
module sfx_tone_channel #(
    parameter int                   CNT_W       = 20,
    parameter int                   DUR_W       = 22,
    parameter int                   SAMPLE_W    = 24,
    parameter logic [SAMPLE_W-1:0]  AMP         = SAMPLE_W'(sfx_pkg::DEF_AMP),
    parameter int                   DECAY_CYC   = sfx_pkg::DEF_DECAY_CYC,
    parameter int                   DECAY_SHIFT = sfx_pkg::DEF_DECAY_SHIFT
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       trig_i,
    input  logic [CNT_W-1:0]           hp_i,
    input  logic [DUR_W-1:0]           dur_i,
    output logic signed [SAMPLE_W-1:0] sample_o,
    output logic                       active_o
);
    import sfx_pkg::*;

    localparam int DCY_W = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;

    logic [CNT_W-1:0]    hp_q;
    logic [CNT_W-1:0]    phase_q;
    logic                level_q;
    logic [DUR_W-1:0]    dur_q;
    logic [SAMPLE_W-1:0] amp_q;
    logic [DCY_W-1:0]    dcnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hp_q    <= '0;
            phase_q <= '0;
            level_q <= 1'b0;
            dur_q   <= '0;
            amp_q   <= '0;
            dcnt_q  <= '0;
        end else if (trig_i) begin
            // a retrigger restarts everything, even mid-tone
            hp_q    <= hp_i;
            phase_q <= '0;
            level_q <= 1'b1;
            dur_q   <= dur_i;
            amp_q   <= AMP;
            dcnt_q  <= '0;
        end else if (dur_q != '0) begin
            dur_q <= dur_q - DUR_W'(1);

            // half-periods below 2 cannot toggle meaningfully: hold DC high
            if (hp_q < CNT_W'(2)) begin
                phase_q <= '0;
                level_q <= 1'b1;
            end else if (phase_q == hp_q - CNT_W'(1)) begin
                phase_q <= '0;
                level_q <= ~level_q;
            end else begin
                phase_q <= phase_q + CNT_W'(1);
            end

            if (dur_q == DUR_W'(1)) begin
                amp_q  <= '0;
                dcnt_q <= '0;
            end else if (DECAY_SHIFT != 0) begin
                if (dcnt_q == DCY_W'(DECAY_CYC - 1)) begin
                    dcnt_q <= '0;
                    // amp >> n never exceeds amp, so this cannot go negative
                    amp_q  <= amp_q - (amp_q >> DECAY_SHIFT);
                end else begin
                    dcnt_q <= dcnt_q + DCY_W'(1);
                end
            end
        end
    end

    assign active_o = (dur_q != '0);
    assign sample_o = !active_o ? '0
                    : (level_q ? $signed(amp_q) : -$signed(amp_q));

endmodule

// File: rtl/sfx_tone_engine.sv
// sfx_tone_engine: multi-channel sound-effect generator feeding the codec.
//   CLOCK_50, reset_n   clock, async active-low reset
//   trig                per-channel one-cycle trigger
//   half_period         per-channel half-period, channel i at [i*CNT_W +: CNT_W]
//   duration            per-channel tone length, channel i at [i*DUR_W +: DUR_W]
//   mute                silence the output, channels keep running
//   codec               write_ready / write / writedata_left / writedata_right
//   active              per-channel sounding flags
//   cur_ch              channel selected by the most-recent-trigger arbiter
module sfx_tone_engine #(
    parameter int                   NUM_CH      = 3,
    parameter int                   CNT_W       = 20,
    parameter int                   DUR_W       = 22,
    parameter int                   SAMPLE_W    = sfx_pkg::SAMPLE_W,
    parameter logic [SAMPLE_W-1:0]  AMP         = SAMPLE_W'(sfx_pkg::DEF_AMP),
    parameter int                   DECAY_CYC   = sfx_pkg::DEF_DECAY_CYC,
    parameter int                   DECAY_SHIFT = sfx_pkg::DEF_DECAY_SHIFT
) (
    input  logic                                 CLOCK_50,
    input  logic                                 reset_n,
    input  logic [NUM_CH-1:0]                    trig,
    input  logic [NUM_CH*CNT_W-1:0]              half_period,
    input  logic [NUM_CH*DUR_W-1:0]              duration,
    input  logic                                 mute,
    sfx_tone_engine_if.master                    codec,
    output logic [NUM_CH-1:0]                    active,
    output logic [sfx_pkg::ch_w(NUM_CH)-1:0]     cur_ch
);
    import sfx_pkg::*;

    localparam int CH_W = ch_w(NUM_CH);

    logic [NUM_CH-1:0]          act;
    logic signed [SAMPLE_W-1:0] smp [NUM_CH];

    logic [CH_W-1:0]            cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]            lo_trig, hi_act;
    logic signed [SAMPLE_W-1:0] sel_d, sel_q, out_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        sfx_tone_channel #(
            .CNT_W       (CNT_W),
            .DUR_W       (DUR_W),
            .SAMPLE_W    (SAMPLE_W),
            .AMP         (AMP),
            .DECAY_CYC   (DECAY_CYC),
            .DECAY_SHIFT (DECAY_SHIFT)
        ) u_ch (
            .clk_i     (CLOCK_50),
            .reset_n_i (reset_n),
            .trig_i    (trig[gi]),
            .hp_i      (half_period[gi*CNT_W +: CNT_W]),
            .dur_i     (duration[gi*DUR_W +: DUR_W]),
            .sample_o  (smp[gi]),
            .active_o  (act[gi])
        );
    end

    always_comb begin
        lo_trig = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (trig[i]) lo_trig = CH_W'(i);
        end
        hi_act = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (act[i]) hi_act = CH_W'(i);
        end
    end

    // newest trigger wins; when the selection dies, fall back to the
    // highest active channel, else keep pointing at the silent one
    always_comb begin
        cur_ch_d = cur_ch_q;
        if (trig != '0) begin
            cur_ch_d = lo_trig;
        end else if (!act[cur_ch_q] && (act != '0)) begin
            cur_ch_d = hi_act;
        end
    end

    always_comb begin
        sel_d = '0;
        if (!mute && act[cur_ch_q]) sel_d = smp[cur_ch_q];
    end

    // two output stages: trigger edge t gives the first sample on the codec
    // bus at t+2
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cur_ch_q <= '0;
            sel_q    <= '0;
            out_q    <= '0;
        end else begin
            cur_ch_q <= cur_ch_d;
            sel_q    <= sel_d;
            out_q    <= sel_q;
        end
    end

    assign codec.write           = codec.write_ready & reset_n;
    assign codec.writedata_left  = out_q;
    assign codec.writedata_right = out_q;
    assign active                = act;
    assign cur_ch                = cur_ch_q;

endmodule

// File: tb/tb_sfx_tone_engine.sv
// Bench for sfx_tone_engine: a time-based reference model (tone shape is
// derived from cycles elapsed since the trigger) compared every cycle,
// plus directed scenarios with hand-computed sample values.
module tb_sfx_tone_engine;

    localparam int NCH   = 3;
    localparam int CW    = 8;
    localparam int DW    = 10;
    localparam int SW    = 24;
    localparam int AMP_T = 1024;
    localparam int DCY_T = 8;
    localparam int SHF_T = 1;

    logic              clk_sys = 1'b0;
    logic              rst_b;
    logic [NCH-1:0]    trig;
    logic [NCH*CW-1:0] hp_bus;
    logic [NCH*DW-1:0] dur_bus;
    logic              mute;
    logic [NCH-1:0]    active;
    logic [1:0]        cur_ch;

    sfx_tone_engine_if #(.SAMPLE_W(SW)) cdc();

    sfx_tone_engine #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DUR_W       (DW),
        .SAMPLE_W    (SW),
        .AMP         (24'd1024),
        .DECAY_CYC   (DCY_T),
        .DECAY_SHIFT (SHF_T)
    ) dut (
        .CLOCK_50    (clk_sys),
        .reset_n     (rst_b),
        .trig        (trig),
        .half_period (hp_bus),
        .duration    (dur_bus),
        .mute        (mute),
        .codec       (cdc),
        .active      (active),
        .cur_ch      (cur_ch)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act_v, input int exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act_v, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int       m_n = 0;
    int       m_cur = 0;
    int       m_sel = 0;
    int       m_wd = 0;
    bit       m_seen [NCH];
    int       m_t0 [NCH];
    int       m_d [NCH];
    int       m_hp [NCH];
    logic [NCH-1:0] a_pre;

    function automatic bit m_act(input int ch, input int nn);
        return m_seen[ch] && ((nn - m_t0[ch]) < m_d[ch]);
    endfunction

    function automatic int m_smp(input int ch, input int nn);
        int k, a;
        bit lvl;
        if (!m_act(ch, nn)) return 0;
        k   = nn - m_t0[ch];
        lvl = (m_hp[ch] < 2) ? 1'b1 : (((k / m_hp[ch]) % 2) == 0);
        a   = AMP_T;
        for (int j = 0; j < k / DCY_T; j++) a = a - (a >> SHF_T);
        return lvl ? a : -a;
    endfunction

    function automatic int m_act_vec();
        int v;
        v = 0;
        for (int c = 0; c < NCH; c++) if (m_act(c, m_n)) v |= (1 << c);
        return v;
    endfunction

    always @(posedge clk_sys) begin
        if (!rst_b) begin
            m_n = 0; m_cur = 0; m_sel = 0; m_wd = 0;
            for (int c = 0; c < NCH; c++) m_seen[c] = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) a_pre[c] = m_act(c, m_n);
            m_wd  = m_sel;
            m_sel = (mute || !a_pre[m_cur]) ? 0 : m_smp(m_cur, m_n);
            if (trig != '0) begin
                for (int c = NCH - 1; c >= 0; c--) if (trig[c]) m_cur = c;
            end else if (!a_pre[m_cur] && (a_pre != '0)) begin
                for (int c = 0; c < NCH; c++) if (a_pre[c]) m_cur = c;
            end
            m_n++;
            for (int c = 0; c < NCH; c++) begin
                if (trig[c]) begin
                    m_seen[c] = 1'b1;
                    m_t0[c]   = m_n;
                    m_d[c]    = int'(dur_bus[c*DW +: DW]);
                    m_hp[c]   = int'(hp_bus[c*CW +: CW]);
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        #1;
        if (!rst_b) begin
            chk("rst_wd", $signed(cdc.writedata_left), 0);
            chk("rst_active", int'(active), 0);
            chk("rst_cur_ch", int'(cur_ch), 0);
            chk("rst_write", int'(cdc.write), 0);
        end else begin
            chk("wd_left", $signed(cdc.writedata_left), m_wd);
            chk("wd_right", $signed(cdc.writedata_right), m_wd);
            chk("active", int'(active), m_act_vec());
            chk("cur_ch", int'(cur_ch), m_cur);
            chk("write", int'(cdc.write), int'(cdc.write_ready));
        end
    end

    // ---------------- stimulus ----------------
    int cap [64];
    int cnt;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic fire(input logic [NCH-1:0] mask, input int hp, input int d);
        @(negedge clk_sys);
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                hp_bus[c*CW +: CW]  = CW'(hp);
                dur_bus[c*DW +: DW] = DW'(d);
            end
        end
        trig = mask;
        @(negedge clk_sys);
        trig = '0;
    endtask

    // cap[i] = writedata after trigger edge t+i
    task automatic capture(input int ch, input int ncyc, output int n_act);
        n_act = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk_sys);
            #1;
            cap[i] = $signed(cdc.writedata_left);
            if (active[ch]) n_act++;
        end
    endtask

    initial begin
        rst_b = 1'b0;
        trig = '0;
        hp_bus = '0;
        dur_bus = '0;
        mute = 1'b0;
        cdc.write_ready = 1'b1;

        wait_neg(3);
        #1;
        chk("h_reset_write", int'(cdc.write), 0);
        @(negedge clk_sys);
        rst_b = 1'b1;
        wait_neg(2);

        // square wave and exact duration on the second paddle channel
        fire(3'b1 << sfx_pkg::CH_P2, 4, 20);
        capture(1, 24, cnt);
        chk("h_sq_t1", cap[1], 0);
        chk("h_sq_t2", cap[2], 1024);
        chk("h_sq_t5", cap[5], 1024);
        chk("h_sq_t6", cap[6], -1024);
        chk("h_sq_t10", cap[10], 512);
        chk("h_sq_t21", cap[21], 256);
        chk("h_sq_t22", cap[22], 0);
        chk("h_sq_len", cnt, 20);
        wait_neg(4);

        // arbitration
        fire(3'b100, 5, 40);
        #1 chk("h_arb_first", int'(cur_ch), 2);
        wait_neg(4);
        fire(3'b001, 3, 10);
        #1 chk("h_arb_second", int'(cur_ch), 0);
        wait_neg(12);
        #1 chk("h_arb_fallback", int'(cur_ch), 2);
        chk("h_arb_active", int'(active), 3'b100);
        wait_neg(30);
        fire(3'b011, 6, 8);
        #1 chk("h_arb_simul", int'(cur_ch), 0);
        chk("h_arb_simul_act", int'(active), 3'b011);
        wait_neg(12);

        // decay
        fire(3'b001, 100, 40);
        capture(0, 20, cnt);
        chk("h_dec_t2", cap[2], 1024);
        chk("h_dec_t9", cap[9], 1024);
        chk("h_dec_t10", cap[10], 512);
        chk("h_dec_t18", cap[18], 256);
        wait_neg(30);

        // zero duration never sounds
        fire(3'b010, 7, 0);
        #1 chk("h_dur0_act", int'(active), 0);
        wait_neg(3);
        #1 chk("h_dur0_act_late", int'(active), 0);
        chk("h_dur0_wd", $signed(cdc.writedata_left), 0);

        // hp=1 gives DC +amp
        fire(3'b100, 1, 12);
        capture(2, 14, cnt);
        chk("h_dc_t2", cap[2], 1024);
        chk("h_dc_t9", cap[9], 1024);
        chk("h_dc_t10", cap[10], 512);
        chk("h_dc_t13", cap[13], 512);
        chk("h_dc_len", cnt, 12);
        wait_neg(5);

        // retrigger with three cycles left
        fire(3'b001, 4, 10);
        wait_neg(6);
        fire(3'b001, 4, 10);
        capture(0, 12, cnt);
        chk("h_rt_old", cap[1], -1024);
        chk("h_rt_new", cap[2], 1024);
        chk("h_rt_len", cnt, 10);
        wait_neg(5);

        // handshake mirror and mute
        fire(3'b010, 6, 60);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_sys);
            cdc.write_ready = 1'($urandom_range(0, 1));
            mute = (i >= 10) && (i < 20);
            if (i == 16) begin
                #1;
                chk("h_mute_wd", $signed(cdc.writedata_left), 0);
                chk("h_mute_active", int'(active[1]), 1);
            end
        end
        @(negedge clk_sys);
        cdc.write_ready = 1'b1;
        mute = 1'b0;
        wait_neg(45);

        // asynchronous reset in the middle of a tone
        fire(3'b001, 4, 100);
        wait_neg(9);
        #2 rst_b = 1'b0;
        #1;
        chk("h_arst_wd", $signed(cdc.writedata_left), 0);
        chk("h_arst_active", int'(active), 0);
        chk("h_arst_write", int'(cdc.write), 0);
        wait_neg(3);
        rst_b = 1'b1;
        wait_neg(10);
        #1;
        chk("h_post_rst_wd", $signed(cdc.writedata_left), 0);
        chk("h_post_rst_active", int'(active), 0);
        chk("h_post_rst_write", int'(cdc.write), 1);

        wait_neg(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
